// File: rtl/sram_pkg.sv
// Shared types and helpers for the sram_dp_bank storage slice.
package sram_pkg;

    typedef enum logic {S_INIT, S_READY} sram_state_e;

    // byte_merge works on words up to this size; callers zero-extend and truncate.
    localparam int unsigned MAX_DW = 256;
    localparam int unsigned MAX_NB = 256;

    function automatic logic rd_latency_ok(input int unsigned lat);
        return (lat == 1) || (lat == 2);
    endfunction

    function automatic logic [MAX_DW-1:0] byte_merge(
        input logic [MAX_DW-1:0] old_w,
        input logic [MAX_DW-1:0] new_w,
        input logic [MAX_NB-1:0] mask,
        input int unsigned       byte_w
    );
        logic [MAX_DW-1:0] w_bm;
        logic [MAX_DW-1:0] w_lane;
        w_bm   = '0;
        w_lane = {MAX_DW{1'b1}} >> (MAX_DW - byte_w);
        for (int unsigned b = 0; b < MAX_NB; b++) begin
            if ((b * byte_w < MAX_DW) && (((mask >> b) & MAX_NB'(1)) != '0)) begin
                w_bm = w_bm | (w_lane << (b * byte_w));
            end
        end
        return (old_w & ~w_bm) | (new_w & w_bm);
    endfunction

endpackage

// File: rtl/sram_core.sv
// Storage array with byte-masked write and registered read; the array itself is never reset.
module sram_core
    import sram_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 14,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned DATA_DEPTH = 16384,
    parameter int unsigned BYTE_WIDTH = 8
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             i_wr_en,
    input  logic [ADDR_WIDTH-1:0]            i_wr_addr,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] i_wr_mask,
    input  logic [DATA_WIDTH-1:0]            i_din,
    input  logic                             i_rd_en,
    input  logic [ADDR_WIDTH-1:0]            i_rd_addr,
    output logic [DATA_WIDTH-1:0]            o_dout
);
    localparam int unsigned NUM_BYTES = DATA_WIDTH / BYTE_WIDTH;
    localparam int unsigned IDX_W     = (DATA_DEPTH > 1) ? $clog2(DATA_DEPTH) : 1;

    logic [DATA_WIDTH-1:0] r_mem [DATA_DEPTH];
    logic [DATA_WIDTH-1:0] r_dout;
    logic [DATA_WIDTH-1:0] w_bitmask;
    logic                  w_wr_in;
    logic                  w_rd_in;
    logic [IDX_W-1:0]      w_widx;
    logic [IDX_W-1:0]      w_ridx;

    for (genvar b = 0; b < NUM_BYTES; b++) begin : g_mask
        assign w_bitmask[b*BYTE_WIDTH +: BYTE_WIDTH] = {BYTE_WIDTH{i_wr_mask[b]}};
    end

    assign w_wr_in = {1'b0, i_wr_addr} < (ADDR_WIDTH+1)'(DATA_DEPTH);
    assign w_rd_in = {1'b0, i_rd_addr} < (ADDR_WIDTH+1)'(DATA_DEPTH);
    assign w_widx  = IDX_W'(i_wr_addr);
    assign w_ridx  = IDX_W'(i_rd_addr);

    always_ff @(posedge clk) begin
        if (i_wr_en && w_wr_in) begin
            r_mem[w_widx] <= (r_mem[w_widx] & ~w_bitmask) | (i_din & w_bitmask);
        end
    end

    // Read register samples the pre-write word; collision handling lives in the top.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dout <= '0;
        end else if (i_rd_en) begin
            r_dout <= w_rd_in ? r_mem[w_ridx] : '0;
        end
    end

    assign o_dout = r_dout;

endmodule

// File: rtl/sram_dp_bank.sv
// Simple-dual-port SRAM bank: init engine, collision policy, 1/2-cycle read latency, read-valid strobe.
module sram_dp_bank
    import sram_pkg::*;
#(
    parameter int unsigned            ADDR_WIDTH = 14,
    parameter int unsigned            DATA_WIDTH = 16,
    parameter int unsigned            DATA_DEPTH = 16384,
    parameter int unsigned            BYTE_WIDTH = 8,
    parameter int unsigned            RD_LATENCY = 1,
    parameter int unsigned            BYPASS     = 1,
    parameter logic [DATA_WIDTH-1:0]  INIT_VALUE = '0
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             wr_en,
    input  logic [ADDR_WIDTH-1:0]            wr_addr,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] wr_mask,
    input  logic [DATA_WIDTH-1:0]            din,
    input  logic                             rd_en,
    input  logic [ADDR_WIDTH-1:0]            rd_addr,
    output logic [DATA_WIDTH-1:0]            dout,
    output logic                             dout_vld,
    output logic                             init_done
);
    localparam int unsigned NUM_BYTES = DATA_WIDTH / BYTE_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DATA_DEPTH - 1);

    if (!rd_latency_ok(RD_LATENCY)) begin : g_bad_latency
        $error("sram_dp_bank: RD_LATENCY must be 1 or 2");
    end
    if (DATA_WIDTH > MAX_DW || (DATA_WIDTH % BYTE_WIDTH) != 0) begin : g_bad_width
        $error("sram_dp_bank: DATA_WIDTH must be a multiple of BYTE_WIDTH and <= MAX_DW");
    end

    sram_state_e           r_state;
    logic [ADDR_WIDTH-1:0] r_init_cnt;
    logic                  r_init_done;
    logic                  r_vld1;
    logic                  r_coll;
    logic [DATA_WIDTH-1:0] r_din_q;
    logic [NUM_BYTES-1:0]  r_mask_q;

    logic                  w_ready;
    logic                  w_rd_acc;
    logic                  w_coll;
    logic                  w_core_we;
    logic [ADDR_WIDTH-1:0] w_core_waddr;
    logic [NUM_BYTES-1:0]  w_core_mask;
    logic [DATA_WIDTH-1:0] w_core_din;
    logic [DATA_WIDTH-1:0] w_core_dout;
    logic [DATA_WIDTH-1:0] w_stage1;

    assign w_ready  = (r_state == S_READY);
    assign w_rd_acc = w_ready && rd_en;
    assign w_coll   = (BYPASS != 0) && w_rd_acc && wr_en && (rd_addr == wr_addr) &&
                      ({1'b0, wr_addr} < (ADDR_WIDTH+1)'(DATA_DEPTH));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_INIT;
            r_init_cnt  <= '0;
            r_init_done <= 1'b0;
        end else begin
            case (r_state)
                S_INIT: begin
                    if (r_init_cnt == LAST_ADDR) begin
                        r_state     <= S_READY;
                        r_init_done <= 1'b1;
                    end else begin
                        r_init_cnt <= r_init_cnt + 1'b1;
                    end
                end
                default: r_state <= S_READY;
            endcase
        end
    end

    always_comb begin
        w_core_we    = wr_en;
        w_core_waddr = wr_addr;
        w_core_mask  = wr_mask;
        w_core_din   = din;
        if (r_state == S_INIT) begin
            w_core_we    = 1'b1;
            w_core_waddr = r_init_cnt;
            w_core_mask  = '1;
            w_core_din   = INIT_VALUE;
        end
    end

    sram_core #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .DATA_DEPTH (DATA_DEPTH),
        .BYTE_WIDTH (BYTE_WIDTH)
    ) u_core (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_wr_en   (w_core_we),
        .i_wr_addr (w_core_waddr),
        .i_wr_mask (w_core_mask),
        .i_din     (w_core_din),
        .i_rd_en   (w_rd_acc),
        .i_rd_addr (rd_addr),
        .o_dout    (w_core_dout)
    );

    // Collision data is captured only with an accepted read so the merged output holds with dout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld1   <= 1'b0;
            r_coll   <= 1'b0;
            r_din_q  <= '0;
            r_mask_q <= '0;
        end else begin
            r_vld1 <= w_rd_acc;
            if (w_rd_acc) begin
                r_coll   <= w_coll;
                r_din_q  <= din;
                r_mask_q <= wr_mask;
            end
        end
    end

    assign w_stage1 = r_coll
        ? DATA_WIDTH'(byte_merge(MAX_DW'(w_core_dout), MAX_DW'(r_din_q), MAX_NB'(r_mask_q), BYTE_WIDTH))
        : w_core_dout;

    if (RD_LATENCY == 2) begin : g_lat2
        logic [DATA_WIDTH-1:0] r_dout2;
        logic                  r_vld2;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_dout2 <= '0;
                r_vld2  <= 1'b0;
            end else begin
                r_vld2 <= r_vld1;
                if (r_vld1) begin
                    r_dout2 <= w_stage1;
                end
            end
        end
        assign dout     = r_dout2;
        assign dout_vld = r_vld2;
    end else begin : g_lat1
        assign dout     = w_stage1;
        assign dout_vld = r_vld1;
    end

    assign init_done = r_init_done;

endmodule

// File: tb/tb_sram_dp_bank.sv
// Scoreboard bench: four sram_dp_bank builds (latency 1/2 x write-first/read-first) share one stimulus stream.
module tb_sram_dp_bank;
    localparam int          AW    = 5;
    localparam int          DW    = 16;
    localparam int          DEPTH = 16;
    localparam int          ND    = 4;
    localparam logic [15:0] INITV = 16'hA5A5;

    typedef struct {
        logic [15:0] data;
        int          edge_n;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [1:0]    wr_mask = '0;
    logic [DW-1:0] din = '0;
    logic          rd_en = 1'b0;
    logic [AW-1:0] rd_addr = '0;

    logic [DW-1:0] dout_a [ND];
    logic          vld_a  [ND];
    logic          idn_a  [ND];

    exp_t          sb [ND][$];
    logic [15:0]   mem [DEPTH];
    logic [15:0]   last [ND];
    int            cyc = 0;
    int            rel = 0;
    int            n_pass = 0;
    int            n_total = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < ND; g++) begin : g_dut
        sram_dp_bank #(
            .ADDR_WIDTH (AW),
            .DATA_WIDTH (DW),
            .DATA_DEPTH (DEPTH),
            .BYTE_WIDTH (8),
            .RD_LATENCY ((g % 2) + 1),
            .BYPASS     (g / 2),
            .INIT_VALUE (INITV)
        ) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .wr_en     (wr_en),
            .wr_addr   (wr_addr),
            .wr_mask   (wr_mask),
            .din       (din),
            .rd_en     (rd_en),
            .rd_addr   (rd_addr),
            .dout      (dout_a[g]),
            .dout_vld  (vld_a[g]),
            .init_done (idn_a[g])
        );
    end

    function automatic int lat(input int d);
        return (d % 2) + 1;
    endfunction

    function automatic logic byp(input int d);
        return d >= 2;
    endfunction

    function automatic logic [15:0] mrg(input logic [15:0] o, input logic [15:0] n, input logic [1:0] m);
        logic [15:0] res;
        res = o;
        if (m[0]) res[7:0]  = n[7:0];
        if (m[1]) res[15:8] = n[15:8];
        return res;
    endfunction

    task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp_v);
        n_total++;
        if (act === exp_v) n_pass++;
        else $display("FAIL %s dut%0d (lat=%0d byp=%0d) t=%0t: got %h expected %h",
                      nm, d, lat(d), byp(d), $time, act, exp_v);
    endtask

    always @(posedge clk) begin
        cyc++;
        if (!rst_n) rel = 0;
        else        rel++;
    end

    // Monitor: pops one expectation per dout_vld, otherwise checks that dout holds.
    always @(negedge clk) begin
        for (int d = 0; d < ND; d++) begin
            if (!rst_n) begin
                last[d] = 16'h0;
            end else begin
                if (vld_a[d]) begin
                    if (sb[d].size() == 0) begin
                        chk("spurious_vld", d, 32'(vld_a[d]), 32'd0);
                    end else begin
                        exp_t e;
                        e = sb[d].pop_front();
                        chk("rd_data", d, 32'(dout_a[d]), 32'(e.data));
                        chk("rd_latency", d, cyc, e.edge_n);
                    end
                    last[d] = dout_a[d];
                end else begin
                    chk("dout_hold", d, 32'(dout_a[d]), 32'(last[d]));
                end
                chk("init_done", d, 32'(idn_a[d]), 32'(rel >= DEPTH));
            end
        end
    end

    // One cycle of stimulus; the model decides acceptance and the expected read word.
    task automatic drive(input logic we, input int wa, input logic [1:0] wm, input logic [15:0] wd,
                         input logic re, input int ra);
        exp_t e;
        wr_en   = we;
        wr_addr = AW'(wa);
        wr_mask = wm;
        din     = wd;
        rd_en   = re;
        rd_addr = AW'(ra);
        if (rst_n && rel >= DEPTH) begin
            if (re) begin
                for (int d = 0; d < ND; d++) begin
                    if (ra >= DEPTH)                     e.data = 16'h0;
                    else if (we && wa == ra && byp(d))   e.data = mrg(mem[ra], wd, wm);
                    else                                 e.data = mem[ra];
                    e.edge_n = cyc + lat(d);
                    sb[d].push_back(e);
                end
            end
            if (we && wa < DEPTH) mem[wa] = mrg(mem[wa], wd, wm);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 0, 2'b00, 16'h0, 1'b0, 0);
    endtask

    task automatic release_reset();
        for (int a = 0; a < DEPTH; a++) mem[a] = INITV;
        rst_n = 1'b1;
        // reads during init must be ignored
        for (int i = 0; i < DEPTH; i++)
            drive(1'b1, $urandom_range(0, DEPTH-1), 2'b11, 16'h0BAD, 1'b1, $urandom_range(0, DEPTH-1));
        for (int a = 0; a < DEPTH; a++) drive(1'b0, 0, 2'b00, 16'h0, 1'b1, a);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        release_reset();

        drive(1'b1, 3, 2'b11, 16'h1234, 1'b0, 0);
        drive(1'b1, 3, 2'b01, 16'hFFEE, 1'b0, 0);
        drive(1'b0, 0, 2'b00, 16'h0,    1'b1, 3);

        drive(1'b1, 5, 2'b10, 16'hBEEF, 1'b1, 5);
        drive(1'b0, 0, 2'b00, 16'h0,    1'b1, 5);

        drive(1'b1, 20, 2'b11, 16'h5555, 1'b0, 0);
        drive(1'b0, 0,  2'b00, 16'h0,    1'b1, 20);
        drive(1'b1, 7,  2'b00, 16'h7777, 1'b0, 0);
        idle(3);

        for (int a = 0; a < DEPTH; a++) drive(1'b0, 0, 2'b00, 16'h0, 1'b1, a);
        idle(5);

        for (int i = 0; i < 300; i++) begin
            int wa;
            int ra;
            wa = $urandom_range(0, DEPTH + 3);
            ra = ($urandom_range(0, 1) == 1) ? wa : $urandom_range(0, DEPTH + 3);
            drive(1'($urandom_range(0, 1)), wa, 2'($urandom_range(0, 3)), 16'($urandom),
                  1'($urandom_range(0, 1)), ra);
        end
        idle(4);

        drive(1'b1, 3, 2'b11, 16'hC0DE, 1'b0, 0);
        for (int a = 0; a < 8; a++) drive(1'b0, 0, 2'b00, 16'h0, 1'b1, a);
        rst_n = 1'b0;
        #1;
        for (int d = 0; d < ND; d++) begin
            chk("rst_dout", d, 32'(dout_a[d]), 32'd0);
            chk("rst_vld",  d, 32'(vld_a[d]),  32'd0);
            chk("rst_init_done", d, 32'(idn_a[d]), 32'd0);
            sb[d].delete();
        end
        wr_en = 1'b0;
        rd_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        release_reset();

        for (int i = 0; i < 20; i++) begin
            int busy;
            busy = 0;
            for (int d = 0; d < ND; d++) busy += sb[d].size();
            if (busy != 0) idle(1);
        end
        for (int d = 0; d < ND; d++) chk("drain", d, 32'(sb[d].size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
